// File: rtl/gate_delay_sequencer.sv
// gate_delay_sequencer: drives a 5-step {A,B} sequence into a NAND gate and measures per-step settle delay
// Ports: clk, rst_n (async, active-low), start (run request, ignored while busy),
//        dut_a/dut_b (registered gate inputs), dut_y (async gate output, synchronized here),
//        busy, done, timeout_err, max_delay (worst per-step delay), worst_idx (first step reaching it).
// Optional macro GATE_SEQ_RISEFALL_EN adds max_rise/max_fall (worst delay on 0->1 / 1->0 output steps).
module gate_delay_sequencer #(
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 200,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] max_delay,
    output logic [2:0]       worst_idx
`ifdef GATE_SEQ_RISEFALL_EN
    ,
    output logic [CNT_W-1:0] max_rise,
    output logic [CNT_W-1:0] max_fall
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_SETTLE, S_DONE} state_t;
    state_t           state;
    logic [2:0]       step;
    logic [CNT_W-1:0] cnt;
    logic             y_m, y_s;
    // Step table is {A,B} = {step[0],1}: odd steps drive 11 (y=0), even steps drive 01 (y=1).
    logic             exp_y;
    assign exp_y = ~step[0];
    // Synchronizer idles at 1, the NAND output for the reset inputs 00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_m <= 1'b1;
            y_s <= 1'b1;
        end else begin
            y_m <= dut_y;
            y_s <= y_m;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            step        <= '0;
            cnt         <= '0;
            dut_a       <= 1'b0;
            dut_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            max_delay   <= '0;
            worst_idx   <= '0;
`ifdef GATE_SEQ_RISEFALL_EN
            max_rise    <= '0;
            max_fall    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    done        <= 1'b0;
                    timeout_err <= 1'b0;
                    max_delay   <= '0;
                    worst_idx   <= '0;
                    step        <= '0;
                    busy        <= 1'b1;
`ifdef GATE_SEQ_RISEFALL_EN
                    max_rise    <= '0;
                    max_fall    <= '0;
`endif
                    state       <= S_APPLY;
                end
                S_APPLY: begin
                    dut_a <= step[0];
                    dut_b <= 1'b1;
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (y_s == exp_y) begin
                    if (cnt > max_delay) begin
                        max_delay <= cnt;
                        worst_idx <= step;
                    end
`ifdef GATE_SEQ_RISEFALL_EN
                    // S0 has no defined edge direction and feeds neither.
                    if (step[0] && cnt > max_fall) max_fall <= cnt;
                    if (!step[0] && step != 3'd0 && cnt > max_rise) max_rise <= cnt;
`endif
                    cnt   <= '0;
                    state <= S_SETTLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    max_delay   <= CNT_W'(TIMEOUT);
                    worst_idx   <= step;
`ifdef GATE_SEQ_RISEFALL_EN
                    if (step[0]) max_fall <= CNT_W'(TIMEOUT);
                    else if (step != 3'd0) max_rise <= CNT_W'(TIMEOUT);
`endif
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt <= '0;
                    if (step == 3'd4) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        step  <= step + 1'b1;
                        state <= S_APPLY;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_delay_sequencer.sv
// tb_gate_delay_sequencer: scoreboard bench for gate_delay_sequencer driving a behavioural NAND gate model
module tb_gate_delay_sequencer;
    localparam int TO = 200;
    typedef struct {
        int md; int wi; int to; int mr; int mf; int a; int b; int rises;
    } exp_t;
    logic       clk, rst_n, start, dut_a, dut_b, dut_y, busy, done, timeout_err;
    logic [7:0] max_delay;
    logic [2:0] worst_idx;
`ifdef GATE_SEQ_RISEFALL_EN
    logic [7:0] max_rise, max_fall;
`endif
    int   vectors = 0, miscompares = 0;
    int   mode = 0, d_rise = 1, d_fall = 1, dc = 0;
    logic y_dly = 1'b1;
    logic tgt;
    int   a_lvl = 0;
    exp_t q[$];
    logic prev_done = 1'b0, prev_a = 1'b0;
    int   rises = 0;

    gate_delay_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .timeout_err(timeout_err), .max_delay(max_delay), .worst_idx(worst_idx)
`ifdef GATE_SEQ_RISEFALL_EN
        , .max_rise(max_rise), .max_fall(max_fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model: mode 0 ideal combinational, 1 separate rise/fall transport delay, 2 output stuck at 1.
    assign tgt   = ~(dut_a & dut_b);
    assign dut_y = (mode == 0) ? tgt : (mode == 2) ? 1'b1 : y_dly;
    always @(posedge clk) begin
        if (tgt != y_dly) begin
            if (dc + 1 >= (tgt ? d_rise : d_fall)) begin
                y_dly <= tgt;
                dc    <= 0;
            end else dc <= dc + 1;
        end else dc <= 0;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected run outcome from the step table and the gate's delays; the synchronizer adds 2 cycles to any output change.
    task automatic predict(output exp_t e);
        int p, t, d;
        e = '{default: 0};
        p = (mode == 2) ? 1 : (a_lvl != 0 ? 0 : 1);
        for (int s = 0; s < 5; s++) begin
            t = (s % 2 == 1) ? 0 : 1;
            e.a = (s % 2 == 1) ? 1 : 0;
            e.b = 1;
            if (s % 2 == 1) e.rises++;
            if (mode == 2 && t == 0) d = TO;
            else if (t == p) d = 0;
            else if (mode == 0) d = 2;
            else d = (t == 1 ? d_rise : d_fall) + 2;
            if (d >= TO) begin
                e.to = 1; e.md = TO; e.wi = s;
                if (s % 2 == 1) e.mf = TO;
                else if (s > 0) e.mr = TO;
                break;
            end
            if (d > e.md) begin e.md = d; e.wi = s; end
            if (s % 2 == 1 && d > e.mf) e.mf = d;
            if (s % 2 == 0 && s > 0 && d > e.mr) e.mr = d;
            if (mode != 2) p = t;
        end
        a_lvl = e.a;
    endtask

    // Monitor: every rising edge of done retires one expected run from the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done <= 1'b0;
            prev_a    <= 1'b0;
            rises     <= 0;
        end else begin
            prev_done <= done;
            prev_a    <= dut_a;
            rises     <= rises + ((busy && dut_a && !prev_a) ? 1 : 0);
            if (done && !prev_done) begin
                rises <= 0;
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("max_delay", int'(max_delay), e.md);
                    chk("worst_idx", int'(worst_idx), e.wi);
                    chk("timeout_err", int'(timeout_err), e.to);
                    chk("busy_at_done", int'(busy), 0);
                    chk("dut_a_final", int'(dut_a), e.a);
                    chk("dut_b_final", int'(dut_b), e.b);
                    chk("a_rises", rises, e.rises);
`ifdef GATE_SEQ_RISEFALL_EN
                    chk("max_rise", int'(max_rise), e.mr);
                    chk("max_fall", int'(max_fall), e.mf);
`endif
                end
            end
        end
    end

    task automatic start_run();
        exp_t e;
        @(negedge clk);
        predict(e);
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
        chk("timeout_cleared", int'(timeout_err), 0);
        chk("max_delay_cleared", int'(max_delay), 0);
        chk("worst_idx_cleared", int'(worst_idx), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic idle();
        repeat ((d_rise > d_fall ? d_rise : d_fall) + 10) @(negedge clk);
    endtask

    task automatic run(input int m, input int dr, input int df);
        mode = m; d_rise = dr; d_fall = df;
        start_run();
        wait_done();
        idle();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dut_a"}, int'(dut_a), 0);
        chk({tag, "_dut_b"}, int'(dut_b), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_timeout"}, int'(timeout_err), 0);
        chk({tag, "_max_delay"}, int'(max_delay), 0);
        chk({tag, "_worst_idx"}, int'(worst_idx), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(0, 1, 1);
        run(1, 5, 5);
        run(1, 9, 3);
        run(2, 1, 1);
        run(0, 1, 1);
        // Start pulse mid-run must be ignored; then a start after done reruns cleanly.
        mode = 0;
        start_run();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        idle();
        run(0, 1, 1);
        run(1, 197, 1);
        run(1, 198, 1);
        for (int i = 0; i < 15; i++) begin
            int r;
            r = $urandom_range(0, 9);
            run(r == 0 ? 0 : (r == 1 ? 2 : 1), $urandom_range(1, 40), $urandom_range(1, 40));
        end
        // Asynchronous reset in the middle of a delayed run.
        mode = 1; d_rise = 10; d_fall = 10;
        start_run();
        repeat (60) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        q.delete();
        a_lvl = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();
        run(0, 1, 1);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
